id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/riscv_pkg.sv | 82 ++++++++
 rtl/id_stage_if.sv | 34 +++
 rtl/regfile.sv | 42 ++++
 rtl/id_stage.sv | 68 ++++++
 tb/tb_id_stage.sv | 138 +++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, immediate-type encoding and decode helpers.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned OPCODE_W   = 7;

    localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    // Registered decode result handed to the execute stage.
    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       rs1;
        logic [XLEN-1:0]       rs2;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rd;
        logic [OPCODE_W-1:0]   opcode;
        logic [2:0]            funct3;
        logic                  funct7b5;
        logic                  we;
        logic                  illegal;
    } id_ex_t;

    // Immediate format per opcode; unsupported opcodes map to IMM_NONE.
    function automatic imm_type_e imm_type(input logic [OPCODE_W-1:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC:            return IMM_U;
            OPC_JAL:                       return IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: return IMM_I;
            OPC_BRANCH:                    return IMM_B;
            OPC_STORE:                     return IMM_S;
            default:                       return IMM_NONE;
        endcase
    endfunction

    function automatic logic is_supported(input logic [OPCODE_W-1:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    // Opcodes that produce a result for rd (rd!=0 is checked by the caller).
    function automatic logic writes_rd(input logic [OPCODE_W-1:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OP_IMM, OPC_OP: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] gen_imm(input logic [XLEN-1:0] i, input imm_type_e t);
        case (t)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: fetched instruction and writeback port in, execute payload out.
// master: fetch/writeback/execute side; slave: id_stage.
interface id_stage_if;
    import riscv_pkg::*;

    logic [XLEN-1:0]       if_id;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;

    logic                  id_ex_valid;
    logic [XLEN-1:0]       id_ex_rs1;
    logic [XLEN-1:0]       id_ex_rs2;
    logic [XLEN-1:0]       id_ex_imm;
    logic [REG_ADDR_W-1:0] id_ex_rd;
    logic [OPCODE_W-1:0]   id_ex_opcode;
    logic [2:0]            id_ex_funct3;
    logic                  id_ex_funct7b5;
    logic                  id_ex_we;
    logic                  id_ex_illegal;

    modport master (
        output if_id, wb_en, wb_rd, wb_data,
        input  id_ex_valid, id_ex_rs1, id_ex_rs2, id_ex_imm, id_ex_rd,
               id_ex_opcode, id_ex_funct3, id_ex_funct7b5, id_ex_we, id_ex_illegal
    );

    modport slave (
        input  if_id, wb_en, wb_rd, wb_data,
        output id_ex_valid, id_ex_rs1, id_ex_rs2, id_ex_imm, id_ex_rd,
               id_ex_opcode, id_ex_funct3, id_ex_funct7b5, id_ex_we, id_ex_illegal
    );

endinterface

// File: rtl/regfile.sv
// 32x32 integer register file with hardwired x0 and write-to-read bypass.
// Ports: clk, res_n (sync, active-high), write port wb_*, two async read ports.
module regfile
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data
);

    logic [XLEN-1:0] regs [NUM_REGS];

    // Storage update; reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (res_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Reads see a same-cycle writeback so decode never picks up a stale value.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = (wb_en && (wb_rd == rs1_addr)) ? wb_data : regs[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rs2_data = (wb_en && (wb_rd == rs2_addr)) ? wb_data : regs[rs2_addr];
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction decode stage: register read, immediate generation, 1-cycle
// registered payload to execute. Ports: clk, res_n (sync, active-high), bus (slave).
module id_stage
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       res_n,
    id_stage_if.slave  bus
);

    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    id_ex_t          nxt;
    id_ex_t          q;

    regfile u_regfile (
        .clk      (clk),
        .res_n    (res_n),
        .wb_en    (bus.wb_en),
        .wb_rd    (bus.wb_rd),
        .wb_data  (bus.wb_data),
        .rs1_addr (bus.if_id[19:15]),
        .rs2_addr (bus.if_id[24:20]),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    // Decode; an all-zero word is a pipeline bubble and leaves everything cleared.
    always_comb begin
        nxt = '0;
        if (bus.if_id != '0) begin
            nxt.valid    = 1'b1;
            nxt.rs1      = rs1_data;
            nxt.rs2      = rs2_data;
            nxt.rd       = bus.if_id[11:7];
            nxt.opcode   = bus.if_id[6:0];
            nxt.funct3   = bus.if_id[14:12];
            nxt.funct7b5 = bus.if_id[30];
            if (is_supported(bus.if_id[6:0])) begin
                nxt.imm = gen_imm(bus.if_id, imm_type(bus.if_id[6:0]));
                nxt.we  = writes_rd(bus.if_id[6:0]) && (bus.if_id[11:7] != '0);
            end else begin
                nxt.illegal = 1'b1;
            end
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (res_n) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

    assign bus.id_ex_valid    = q.valid;
    assign bus.id_ex_rs1      = q.rs1;
    assign bus.id_ex_rs2      = q.rs2;
    assign bus.id_ex_imm      = q.imm;
    assign bus.id_ex_rd       = q.rd;
    assign bus.id_ex_opcode   = q.opcode;
    assign bus.id_ex_funct3   = q.funct3;
    assign bus.id_ex_funct7b5 = q.funct7b5;
    assign bus.id_ex_we       = q.we;
    assign bus.id_ex_illegal  = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed, table-driven bench for id_stage with hand-computed expectations.
module tb_id_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        valid;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        b5;
        logic        we;
        logic        ill;
    } vec_t;

    localparam int NVEC = 14;

    logic clk;
    logic res_n;
    int   n_checks;
    int   n_fail;
    vec_t vecs [NVEC];
    vec_t hv;

    id_stage_if bus ();

    id_stage dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " valid"},   32'(bus.id_ex_valid),    32'(v.valid));
        check({tag, " rs1"},     bus.id_ex_rs1,           v.rs1);
        check({tag, " rs2"},     bus.id_ex_rs2,           v.rs2);
        check({tag, " imm"},     bus.id_ex_imm,           v.imm);
        check({tag, " rd"},      32'(bus.id_ex_rd),       32'(v.rd));
        check({tag, " opcode"},  32'(bus.id_ex_opcode),   32'(v.opc));
        check({tag, " funct3"},  32'(bus.id_ex_funct3),   32'(v.f3));
        check({tag, " f7b5"},    32'(bus.id_ex_funct7b5), 32'(v.b5));
        check({tag, " we"},      32'(bus.id_ex_we),       32'(v.we));
        check({tag, " illegal"}, 32'(bus.id_ex_illegal),  32'(v.ill));
    endtask

    task automatic drive(input logic r, input logic [31:0] instr, input logic en,
                         input logic [4:0] rd, input logic [31:0] data);
        res_n       = r;
        bus.if_id   = instr;
        bus.wb_en   = en;
        bus.wb_rd   = rd;
        bus.wb_data = data;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //            instr         wen   wrd    wdata         v     rs1           rs2           imm           rd      opcode       f3    b5    we    ill
        vecs[0]  = '{32'h00500093, 1'b0, 5'd0, 32'h0,        1'b1, 32'h0,        32'h0,        32'h00000005, 5'd1,  7'b0010011, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{32'h00108133, 1'b1, 5'd1, 32'h00001234, 1'b1, 32'h00001234, 32'h00001234, 32'h0,        5'd2,  7'b0110011, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h00108133, 1'b0, 5'd0, 32'h0,        1'b1, 32'h00001234, 32'h00001234, 32'h0,        5'd2,  7'b0110011, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'h00000033, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 32'h0,        32'h0,        32'h0,        5'd0,  7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h00000033, 1'b0, 5'd0, 32'h0,        1'b1, 32'h0,        32'h0,        32'h0,        5'd0,  7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'hFE000EE3, 1'b0, 5'd0, 32'h0,        1'b1, 32'h0,        32'h0,        32'hFFFFFFFC, 5'd29, 7'b1100011, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b1, 32'h0,        32'h0,        32'h0,        5'd31, 7'b1111111, 3'd7, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'h00000000, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,        32'h0,        5'd0,  7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'hA5A5A2B7, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 32'h0,        32'h0,        32'hA5A5A000, 5'd5,  7'b0110111, 3'd2, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{32'hFE50AC23, 1'b0, 5'd0, 32'h0,        1'b1, 32'h00001234, 32'hA5A5A5A5, 32'hFFFFFFF8, 5'd24, 7'b0100011, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{32'hFFFFF0EF, 1'b0, 5'd0, 32'h0,        1'b1, 32'h0,        32'h0,        32'hFFFFFFFE, 5'd1,  7'b1101111, 3'd7, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{32'h00001017, 1'b0, 5'd0, 32'h0,        1'b1, 32'h0,        32'h0,        32'h00001000, 5'd0,  7'b0010111, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'h01028367, 1'b0, 5'd0, 32'h0,        1'b1, 32'hA5A5A5A5, 32'h0,        32'h00000010, 5'd6,  7'b1100111, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{32'hFFF02383, 1'b0, 5'd0, 32'h0,        1'b1, 32'h0,        32'h0,        32'hFFFFFFFF, 5'd7,  7'b0000011, 3'd2, 1'b1, 1'b1, 1'b0};

        // Reset with a non-bubble instruction and a competing write to x3.
        drive(1'b1, 32'hFFFFFFFF, 1'b1, 5'd3, 32'h7);
        @(posedge clk);
        #1;
        hv = '0;
        check_all("reset0", hv);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(1'b0, vecs[i].instr, vecs[i].wb_en, vecs[i].wb_rd, vecs[i].wb_data);
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vecs[i]);
        end

        // Reset while x5 holds data and a write to x5 is attempted: all outputs cleared.
        @(negedge clk);
        drive(1'b1, 32'h00500093, 1'b1, 5'd5, 32'h00000001);
        @(posedge clk);
        #1;
        hv = '0;
        check_all("reset1", hv);

        // add x8,x5,x0 after reset: x5 must read 0 (reset cleared it, write dropped).
        @(negedge clk);
        drive(1'b0, 32'h00028433, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        hv = '{32'h00028433, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0,
               5'd8, 7'b0110011, 3'd0, 1'b0, 1'b1, 1'b0};
        check_all("post_rst_x5", hv);

        // add x9,x3,x1: x3 write during first reset dropped, x1 cleared by second reset.
        @(negedge clk);
        drive(1'b0, 32'h001184B3, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        hv = '{32'h001184B3, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0,
               5'd9, 7'b0110011, 3'd0, 1'b0, 1'b1, 1'b0};
        check_all("post_rst_x3x1", hv);

        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
